// File: rtl/garage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : garage_pkg
// Purpose  : Shared constants for the garage door input conditioning path.
//            Provides the default synchronizer depth, the default debounce
//            interval, and the active logic levels of the button and the
//            limit switches.
// Revision : 1.0 - initial release
// ============================================================================
package garage_pkg;

    localparam int   c_DEFAULT_SYNC_STAGES     = 2;
    localparam int   c_DEFAULT_DEBOUNCE_CYCLES = 16;

    // Active levels of the physical inputs.
    localparam logic PRESSED   = 1'b1;
    localparam logic LIMIT_HIT = 1'b1;

endpackage : garage_pkg
`default_nettype wire

// File: rtl/debounce_channel.sv
`default_nettype none
// ============================================================================
// Module   : debounce_channel
// Purpose  : One input conditioning channel. The raw asynchronous level goes
//            through a SYNC_STAGES flop chain. The debounced level then
//            follows the synchronized value only after that value has
//            differed from it for DEBOUNCE_CYCLES consecutive clocks. Any
//            cycle of agreement restarts the qualification.
// Ports    : clk     - system clock
//            rst     - asynchronous active-high reset
//            i_raw   - raw asynchronous input level
//            o_level - debounced level
// Revision : 1.0 - initial release
// ============================================================================
module debounce_channel
    import garage_pkg::*;
#(
    parameter int SYNC_STAGES     = c_DEFAULT_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = c_DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_level
);

    localparam int              CNT_W       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] c_CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
        $error("debounce_channel: SYNC_STAGES must be at least 2");
    end
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce_cycles
        $error("debounce_channel: DEBOUNCE_CYCLES must be at least 2");
    end

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_level;
    logic                   w_sync;

    assign w_sync  = r_sync[SYNC_STAGES-1];
    assign o_level = r_level;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync  <= '0;
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
            if (w_sync == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_MAX) begin
                // Disagreement has persisted for the full interval.
                r_level <= w_sync;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule : debounce_channel
`default_nettype wire

// File: rtl/garage_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : garage_input_conditioner
// Purpose  : Conditions the wall button and the two limit switches ahead of
//            the garage door controller. Each input is synchronized and
//            debounced. The button is turned into a one-cycle Activate pulse
//            on each debounced press. The block also flags the case where
//            both limits are asserted at the same time.
// Ports    : CLK        - system clock
//            RST        - asynchronous active-high reset
//            btn_raw    - raw wall button, 1 = pressed
//            up_lim_raw - raw upper limit switch, 1 = fully open
//            dn_lim_raw - raw lower limit switch, 1 = fully closed
//            Activate   - one-cycle pulse per debounced press
//            UP_Max     - debounced upper limit level
//            DN_Max     - debounced lower limit level
//            lim_fault  - registered, 1 while UP_Max and DN_Max are both 1
// Revision : 1.0 - initial release
// ============================================================================
module garage_input_conditioner
    import garage_pkg::*;
#(
    parameter int SYNC_STAGES     = c_DEFAULT_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = c_DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic CLK,
    input  logic RST,
    input  logic btn_raw,
    input  logic up_lim_raw,
    input  logic dn_lim_raw,
    output logic Activate,
    output logic UP_Max,
    output logic DN_Max,
    output logic lim_fault
);

    logic w_btn_d;
    logic w_up_d;
    logic w_dn_d;
    logic w_btn_pressed;
    logic w_up_hit;
    logic w_dn_hit;

    logic r_btn_d_q;
    logic r_activate;
    logic r_lim_fault;

    debounce_channel #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn (
        .clk     (CLK),
        .rst     (RST),
        .i_raw   (btn_raw),
        .o_level (w_btn_d)
    );

    debounce_channel #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_up_lim (
        .clk     (CLK),
        .rst     (RST),
        .i_raw   (up_lim_raw),
        .o_level (w_up_d)
    );

    debounce_channel #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_dn_lim (
        .clk     (CLK),
        .rst     (RST),
        .i_raw   (dn_lim_raw),
        .o_level (w_dn_d)
    );

    assign w_btn_pressed = (w_btn_d == PRESSED);
    assign w_up_hit      = (w_up_d == LIMIT_HIT);
    assign w_dn_hit      = (w_dn_d == LIMIT_HIT);

    // Rising-edge detector on the debounced button. The fault flag is
    // informational only. The limit levels pass through unmasked.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_btn_d_q   <= 1'b0;
            r_activate  <= 1'b0;
            r_lim_fault <= 1'b0;
        end else begin
            r_btn_d_q   <= w_btn_pressed;
            r_activate  <= w_btn_pressed & ~r_btn_d_q;
            r_lim_fault <= w_up_hit & w_dn_hit;
        end
    end

    assign Activate  = r_activate;
    assign UP_Max    = w_up_hit;
    assign DN_Max    = w_dn_hit;
    assign lim_fault = r_lim_fault;

endmodule : garage_input_conditioner
`default_nettype wire
